// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared widths, default timing and FSM state type for the SRAM controller
package sram_pkg;
    localparam int ADDR_W              = 20;
    localparam int DATA_W              = 32;
    localparam int BE_W                = DATA_W / 8;
    localparam int CNT_W               = 4;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD
    } state_t;
endpackage

// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - core-side request/response bus of the SRAM controller
interface sram_ctrl_if;
    import sram_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_wmask;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-port asynchronous SRAM controller with programmable strobe width
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_ctrl_if.slave        bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [BE_W-1:0]   ram_be_n,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [DATA_W-1:0] ram_dout,
    output logic              ram_doe,
    input  logic [DATA_W-1:0] ram_din
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("sram_ctrl: WAIT_CYCLES must be within 1..15");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [BE_W-1:0]   wmask_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rd_done_q;
    logic              accept;
    logic              capture;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_LAST;
                    state_next = bus.req_we ? ST_WR_SETUP : ST_READ;
                end
            end
            ST_READ: begin
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_WR_SETUP: begin
                cnt_next   = CNT_LAST;
                state_next = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                if (cnt == '0) begin
                    state_next = ST_WR_HOLD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_WR_HOLD: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            ram_addr  <= '0;
            ram_dout  <= '0;
            wmask_q   <= '0;
            rdata_q   <= '0;
            rd_done_q <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            rd_done_q <= capture;
            if (accept) begin
                ram_addr <= bus.req_addr;
                ram_dout <= bus.req_wdata;
                wmask_q  <= bus.req_wmask;
            end
            if (capture) begin
                rdata_q <= ram_din;
            end
        end
    end

    // Strobes decode straight from the state register so reset releases the pins without a clock.
    always_comb begin
        ram_ce_n = 1'b1;
        ram_oe_n = 1'b1;
        ram_we_n = 1'b1;
        ram_doe  = 1'b0;
        ram_be_n = '1;
        case (state)
            ST_READ: begin
                ram_ce_n = 1'b0;
                ram_oe_n = 1'b0;
                ram_be_n = '0;
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                ram_ce_n = 1'b0;
                ram_doe  = 1'b1;
                ram_be_n = ~wmask_q;
            end
            ST_WR_PULSE: begin
                ram_ce_n = 1'b0;
                ram_we_n = 1'b0;
                ram_doe  = 1'b1;
                ram_be_n = ~wmask_q;
            end
            default: begin
                ram_ce_n = 1'b1;
            end
        endcase
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = rd_done_q | (state == ST_WR_HOLD);
    assign bus.resp_rdata = rdata_q;

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set access-strobe length in clk cycles; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  core request present.
REQ-005 req_ready  output  1  controller can accept a request this cycle.
REQ-006 req_we  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  20  word address.
REQ-008 req_wdata  input  32  write data.
REQ-009 req_wmask  input  4  byte-write mask, active-high.
REQ-010 resp_valid  output  1  single-cycle completion pulse (read or write).
REQ-011 resp_rdata  output  32  read data, valid with resp_valid on reads.
REQ-012 ram_addr  output  20  SRAM address pins.
REQ-013 ram_be_n  output  4  SRAM byte enables, active-low.
REQ-014 ram_ce_n / ram_oe_n / ram_we_n  output  1 each  SRAM strobes, active-low.
REQ-015 ram_dout  output  32  data to drive onto the pad.
REQ-016 ram_doe  output  1  pad output enable; 1 = drive ram_dout.
REQ-017 ram_din  input  32  data sampled from the pad.

Function
REQ-018 States SHALL be IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD; 4-bit wait counter.
REQ-019 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready at edge T.
REQ-020 At acceptance, addr, we, wdata, wmask SHALL be registered; the input bus is ignored until the next IDLE.
REQ-021 Read: cycles T+1..T+WAIT_CYCLES in READ with ce_n=0, oe_n=0, we_n=1, be_n=4'b0000, doe=0.
REQ-022 Read: ram_din SHALL be captured at the edge ending the last READ cycle; resp_valid=1 and resp_rdata=captured data in cycle T+WAIT_CYCLES+1, state IDLE in that cycle.
REQ-023 Write: cycle T+1 WR_SETUP (ce_n=0, we_n=1, oe_n=1, doe=1, be_n=~wmask).
REQ-024 Write: cycles T+2..T+WAIT_CYCLES+1 WR_PULSE, same as WR_SETUP but we_n=0.
REQ-025 Write: cycle T+WAIT_CYCLES+2 WR_HOLD (ce_n=0, we_n=1, doe=1), resp_valid=1; next cycle IDLE.
REQ-026 ram_doe SHALL never be 1 while ram_oe_n=0 (no bus contention).
REQ-027 In IDLE: ce_n=oe_n=we_n=1, doe=0, be_n=4'b1111, ram_addr holds last value.
REQ-028 resp_rdata SHALL hold its last read value until the next read completes; writes do not alter it.
REQ-029 No response back-pressure; consumer SHALL accept resp_valid when pulsed.
REQ-030 req_valid while busy SHALL have no effect; earliest next acceptance is the response cycle of a read, the cycle after WR_HOLD for a write.
REQ-031 Write with wmask=4'b0000 SHALL still run the full sequence with be_n=4'b1111.
REQ-032 Throughput: one read per WAIT_CYCLES+1 cycles, one write per WAIT_CYCLES+3 cycles.

Reset
REQ-033 rst_n low SHALL immediately (no clock) force state IDLE, counter 0, ce_n=oe_n=we_n=1, doe=0, be_n=4'b1111, ram_addr=0, ram_dout=0, resp_valid=0, resp_rdata=0.
REQ-034 Reset mid-access SHALL abort without a response; the first acceptance is on the first edge after rst_n rises.

Structure
REQ-035 Package sram_pkg SHALL hold the state enum, default WAIT_CYCLES, and address/data width constants.
REQ-036 Block SHALL be flat; tristate pad (ram_doe/ram_dout/ram_din to inout) SHALL live in sub-module sram_pad, instantiated by the top level, not here.

Verification
REQ-037 WAIT_CYCLES=2, read addr 0x00010, model returns 0xDEADBEEF -> oe_n low cycles T+1..T+2, resp_valid at T+3, resp_rdata=0xDEADBEEF.
REQ-038 Write addr 0x00020 data 0x12345678 mask 4'b0101 -> be_n=4'b1010, we_n low exactly T+2..T+3, resp_valid at T+4, doe=1 T+1..T+4.
REQ-039 Back-to-back: read held valid continuously -> accepted every 3 cycles, req_ready low in between.
REQ-040 rst_n low during WR_PULSE -> we_n=1 and doe=0 same cycle, no resp_valid; read issued after reset returns correct data.
REQ-041 WAIT_CYCLES=1 and 15 -> strobe widths 1 and 15 cycles; assertion: never doe=1 && oe_n=0.
REQ-042 Write then read same address -> resp_rdata equals written bytes per mask; read between writes leaves resp_rdata unchanged by writes.
